// File: rtl/vga_tile_line_renderer.sv
// Tile-map line renderer: fills a ping-pong pair of 640-pixel line buffers from
// a tile-map RAM and pattern ROM, and serves pixels combinationally from the front one.
module vga_tile_line_renderer #(
   parameter int unsigned TRIG_COL = 656,
   parameter int unsigned H_PIX    = 640,
   parameter int unsigned V_PIX    = 480
) (
   input  logic        vga_clk,
   input  logic        clrn,
   input  logic [8:0]  row_addr_i,
   input  logic [9:0]  col_addr_i,
   input  logic        rdn_i,
   output logic [7:0]  d_in_o,
   output logic [12:0] map_addr_o,
   input  logic [7:0]  map_data_i,
   output logic [13:0] pat_addr_o,
   input  logic [7:0]  pat_data_i,
   output logic        busy_o,
   output logic        ovf_o
);

   localparam int unsigned TILES = H_PIX / 8;
   localparam logic [9:0]  TRIG  = 10'(TRIG_COL);
   localparam logic [9:0]  H_LIM = 10'(H_PIX);
   localparam logic [8:0]  V_LIM = 9'(V_PIX);
   localparam logic [6:0]  TLAST = 7'(TILES - 1);

   typedef enum logic [1:0] {IDLE, MAP, PIX, DONE} state_t;

   state_t      state_q, state_d;
   logic        trig_q;
   logic [8:0]  row_q;
   logic [5:0]  trow_q, trow_d;
   logic [2:0]  y_q, y_d;
   logic [6:0]  tcol_q, tcol_d;
   logic [2:0]  x_q, x_d;
   logic [12:0] map_addr_q, map_addr_d;
   logic        front_q, front_d;
   logic [1:0]  valid_q, valid_d;
   logic        ovf_q, ovf_d;
   logic        wr_en_q, wr_en_d;
   logic [9:0]  wr_addr_q, wr_addr_d;
   logic [7:0]  tile_q, tile_d;
   logic [7:0]  tile_sel;
   logic [8:0]  target;

   logic [7:0]  buf0_q [H_PIX];
   logic [7:0]  buf1_q [H_PIX];

   // The target row wraps in 9 bits so rows 510/511 prefetch lines 0/1.
   assign target   = row_q + 9'd2;
   assign tile_sel = (x_q == 3'd0) ? map_data_i : tile_q;

   assign map_addr_o = map_addr_q;
   assign pat_addr_o = (state_q == PIX) ? {tile_sel, y_q, x_q} : 14'd0;
   assign busy_o     = (state_q != IDLE);
   assign ovf_o      = ovf_q;

   always_comb begin
      state_d    = state_q;
      trow_d     = trow_q;
      y_d        = y_q;
      tcol_d     = tcol_q;
      x_d        = x_q;
      map_addr_d = map_addr_q;
      front_d    = front_q;
      valid_d    = valid_q;
      ovf_d      = ovf_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      tile_d     = tile_q;

      case (state_q)
         MAP: begin
            x_d     = 3'd0;
            state_d = PIX;
         end
         PIX: begin
            wr_en_d   = 1'b1;
            wr_addr_d = {tcol_q, x_q};
            tile_d    = tile_sel;
            x_d       = x_q + 3'd1;
            if (x_q == 3'd7) begin
               if (tcol_q == TLAST) begin
                  state_d = DONE;
               end else begin
                  tcol_d     = tcol_q + 7'd1;
                  map_addr_d = map_addr_q + 13'd1;
                  state_d    = MAP;
               end
            end
         end
         DONE: begin
            valid_d[front_q ^ 1'b1] = 1'b1;
            state_d                 = IDLE;
         end
         default: ;
      endcase

      // A trigger always wins: an unfinished fill is dropped and its buffer stays invalid.
      if (trig_q) begin
         if (state_q != IDLE) ovf_d = 1'b1;
         valid_d          = valid_q;
         valid_d[front_q] = 1'b0;
         front_d          = ~front_q;
         wr_en_d          = 1'b0;
         if (target < V_LIM) begin
            trow_d     = target[8:3];
            y_d        = target[2:0];
            tcol_d     = 7'd0;
            x_d        = 3'd0;
            map_addr_d = 13'(target[8:3]) * 13'(TILES);
            state_d    = MAP;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         state_q    <= IDLE;
         trig_q     <= 1'b0;
         row_q      <= 9'd0;
         trow_q     <= 6'd0;
         y_q        <= 3'd0;
         tcol_q     <= 7'd0;
         x_q        <= 3'd0;
         map_addr_q <= 13'd0;
         front_q    <= 1'b0;
         valid_q    <= 2'b00;
         ovf_q      <= 1'b0;
         wr_en_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         trig_q     <= (col_addr_i == TRIG);
         row_q      <= row_addr_i;
         trow_q     <= trow_d;
         y_q        <= y_d;
         tcol_q     <= tcol_d;
         x_q        <= x_d;
         map_addr_q <= map_addr_d;
         front_q    <= front_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
         wr_en_q    <= wr_en_d;
      end
   end

   always_ff @(posedge vga_clk) begin
      wr_addr_q <= wr_addr_d;
      tile_q    <= tile_d;
   end

   // Pattern data lags its address by one cycle; it lands in the back buffer only.
   always_ff @(posedge vga_clk) begin
      if (wr_en_q && !trig_q) begin
         if (front_q) buf0_q[wr_addr_q] <= pat_data_i;
         else         buf1_q[wr_addr_q] <= pat_data_i;
      end
   end

   always_comb begin
      d_in_o = 8'd0;
      if (!rdn_i && (col_addr_i < H_LIM) && valid_q[front_q])
         d_in_o = front_q ? buf1_q[col_addr_i] : buf0_q[col_addr_i];
   end

endmodule
